// File: rtl/axi_tdd_ng_sync_gen_mc.sv
`default_nettype none
// ============================================================================
//  Module      : axi_tdd_ng_sync_gen_mc
//  Description : Multi-source TDD frame-sync generator. Merges external sync
//                inputs, an internal periodic generator and a software strobe
//                into one registered single-cycle sync pulse, with per-input
//                mask/polarity, post-sync holdoff, one-shot arming and an
//                emitted-sync counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_tdd_ng_sync_gen_mc #(
    parameter int NUM_EXT           = 2,
    parameter int SYNC_EXTERNAL     = 1,
    parameter int SYNC_EXTERNAL_CDC = 1,
    parameter int SYNC_INTERNAL     = 1,
    parameter int SYNC_COUNT_WIDTH  = 64,
    parameter int HOLDOFF_WIDTH     = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_EXT-1:0]          sync_in,
    output logic                        sync_out,
    output logic                        sync_armed,
    output logic [31:0]                 sync_count,
    input  logic                        tdd_enable,
    input  logic                        tdd_sync_ext,
    input  logic [NUM_EXT-1:0]          tdd_sync_ext_mask,
    input  logic [NUM_EXT-1:0]          tdd_sync_ext_pol,
    input  logic                        tdd_sync_int,
    input  logic                        tdd_sync_soft,
    input  logic [SYNC_COUNT_WIDTH-1:0] tdd_sync_period,
    input  logic [HOLDOFF_WIDTH-1:0]    tdd_sync_holdoff,
    input  logic                        tdd_sync_oneshot,
    input  logic                        tdd_sync_arm
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READY = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    localparam logic [SYNC_COUNT_WIDTH-1:0] c_CNT_ONE  = {{(SYNC_COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HOLDOFF_WIDTH-1:0]    c_HOLD_ONE = {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};

    // Reset and block disable share one clear path, which overrides everything.
    logic w_clear;
    assign w_clear = ~resetn | ~tdd_enable;

    logic [NUM_EXT-1:0] w_ext_p;
    logic               w_int_raw;

    // ------------------------------------------------------------------------
    // External source conditioning
    // ------------------------------------------------------------------------
    generate
        if (SYNC_EXTERNAL == 0) begin : g_ext_off
            assign w_ext_p = '0;
        end else if (SYNC_EXTERNAL_CDC != 0) begin : g_ext_cdc
            logic [NUM_EXT-1:0] r_m1;
            logic [NUM_EXT-1:0] r_m2;
            logic [NUM_EXT-1:0] r_m3;

            // Polarity-corrected synchronizer chain; third stage feeds the edge detector.
            always_ff @(posedge clk) begin
                if (w_clear) begin
                    r_m1 <= '0;
                    r_m2 <= '0;
                    r_m3 <= '0;
                end else begin
                    r_m1 <= sync_in ^ tdd_sync_ext_pol;
                    r_m2 <= r_m1;
                    r_m3 <= r_m2;
                end
            end

            assign w_ext_p = r_m2 & ~r_m3;
        end else begin : g_ext_sync
            // Inputs are already clk-synchronous single-cycle pulses.
            assign w_ext_p = sync_in ^ tdd_sync_ext_pol;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Internal periodic generator
    // ------------------------------------------------------------------------
    generate
        if (SYNC_INTERNAL != 0) begin : g_int_on
            logic [SYNC_COUNT_WIDTH-1:0] r_period_cnt;
            logic [SYNC_COUNT_WIDTH-1:0] w_period_last;
            logic                        w_period_zero;
            logic                        w_at_last;

            assign w_period_last = tdd_sync_period - c_CNT_ONE;
            assign w_period_zero = (tdd_sync_period == '0);
            assign w_at_last     = (r_period_cnt == w_period_last);

            // Free-running 0..P-1 counter; held at 0 while the period is zero.
            // If the period shrinks below the current count, it runs on to wrap.
            always_ff @(posedge clk) begin
                if (w_clear || w_period_zero) begin
                    r_period_cnt <= '0;
                end else if (w_at_last) begin
                    r_period_cnt <= '0;
                end else begin
                    r_period_cnt <= r_period_cnt + c_CNT_ONE;
                end
            end

            assign w_int_raw = tdd_sync_int & w_at_last & ~w_period_zero;
        end else begin : g_int_off
            assign w_int_raw = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Source merge, gating and holdoff FSM
    // ------------------------------------------------------------------------
    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [HOLDOFF_WIDTH-1:0] r_hold_cnt;
    logic [HOLDOFF_WIDTH-1:0] w_hold_nxt;
    logic                     r_armed;
    logic                     r_sync_out;
    logic [31:0]              r_sync_count;

    logic w_ext_raw;
    logic w_gate_ok;
    logic w_in_hold;
    logic w_gated;
    logic w_emit;
    logic w_hold_zero;

    assign w_ext_raw   = tdd_sync_ext & (|(w_ext_p & tdd_sync_ext_mask));
    assign w_gate_ok   = ~tdd_sync_oneshot | r_armed;
    assign w_in_hold   = (r_state == c_ST_HOLD);
    // Gated events arriving during holdoff are dropped, never queued.
    assign w_gated     = (w_ext_raw | w_int_raw) & w_gate_ok & ~w_in_hold;
    // The software strobe bypasses both arming and holdoff.
    assign w_emit      = w_gated | tdd_sync_soft;
    assign w_hold_zero = (tdd_sync_holdoff == '0);

    // Next-state logic: each emit opens a window of exactly H suppressed cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            c_ST_IDLE, c_ST_READY: begin
                w_state_nxt = c_ST_READY;
                if (w_emit && !w_hold_zero) begin
                    w_state_nxt = c_ST_HOLD;
                    w_hold_nxt  = tdd_sync_holdoff;
                end
            end
            c_ST_HOLD: begin
                if (w_emit) begin
                    w_hold_nxt  = tdd_sync_holdoff;
                    w_state_nxt = w_hold_zero ? c_ST_READY : c_ST_HOLD;
                end else if (r_hold_cnt <= c_HOLD_ONE) begin
                    w_state_nxt = c_ST_READY;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold_cnt - c_HOLD_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // State, output pulse, arm flag and emitted-sync counter registers.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state      <= c_ST_IDLE;
            r_hold_cnt   <= '0;
            r_sync_out   <= 1'b0;
            r_armed      <= 1'b0;
            r_sync_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_sync_out <= w_emit;
            // An arm strobe wins over a simultaneous emit.
            r_armed    <= tdd_sync_arm | (r_armed & ~w_emit);
            if (w_emit) begin
                r_sync_count <= r_sync_count + 32'd1;
            end
        end
    end

    assign sync_out   = r_sync_out;
    assign sync_armed = r_armed;
    assign sync_count = r_sync_count;

endmodule
`default_nettype wire

// File: doc/axi_tdd_ng_sync_gen_mc.md
Name: axi_tdd_ng_sync_gen_mc

Overview:
Multi-source TDD frame-sync generator for the axi_tdd_ng core.
- Merges NUM_EXT external sync inputs, an internal periodic generator and a software strobe into one single-cycle sync_out pulse.
- Adds per-input masking and polarity, exact-period internal timing, post-sync holdoff, one-shot arm mode and an emitted-sync counter.
- Sits between the register map and the TDD counter/channel logic in the clk domain.

Parameters:
NUM_EXT, 2, number of external sync inputs (1..8)
SYNC_EXTERNAL, 1, 0 forces all external sources to 0
SYNC_EXTERNAL_CDC, 1, 1 = inputs asynchronous (3-FF sync + edge detect); 0 = inputs are clk-synchronous single-cycle pulses
SYNC_INTERNAL, 1, 0 removes the internal generator (source = 0)
SYNC_COUNT_WIDTH, 64, width of the internal period counter
HOLDOFF_WIDTH, 16, width of the holdoff counter

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
sync_in  in  NUM_EXT  external sync inputs
sync_out  out  1  registered single-cycle sync pulse
sync_armed  out  1  one-shot armed status
sync_count  out  32  number of emitted syncs, wraps
tdd_enable  in  1  block enable; low = clear state
tdd_sync_ext  in  1  global enable for external sources
tdd_sync_ext_mask  in  NUM_EXT  per-input enable
tdd_sync_ext_pol  in  NUM_EXT  1 = input active-low / falling edge
tdd_sync_int  in  1  enable internal source
tdd_sync_soft  in  1  software sync strobe, one cycle
tdd_sync_period  in  SYNC_COUNT_WIDTH  internal period P in clk cycles
tdd_sync_holdoff  in  HOLDOFF_WIDTH  suppression window H after each sync
tdd_sync_oneshot  in  1  1 = gated sources emit only when armed
tdd_sync_arm  in  1  one-cycle arm strobe

Behaviour:
- Reset (resetn=0) or tdd_enable=0, same clear: sync_out=0, sync_armed=0, sync_count=0; CDC regs, period counter and holdoff counter go to 0; FSM to IDLE. Clear has priority over all other inputs.
- External path, CDC=1, per input i:
  - m1 <= sync_in[i] ^ pol[i]; m2 <= m1; m3 <= m2; ext_p[i] = m2 & ~m3.
  - sync_out asserts 3 clk edges after the edge that first samples the active level.
- External path, CDC=0: ext_p[i] = sync_in[i] ^ pol[i], combinational; sync_out asserts 1 edge later.
- ext_raw = tdd_sync_ext & |(ext_p & tdd_sync_ext_mask).
- Internal generator:
  - Counter starts at 0 on the first enabled cycle and counts 0..P-1, then wraps.
  - int_raw = tdd_sync_int & (counter == P-1) & (P != 0).
  - P=0: generator idle, counter held at 0. P=1: int_raw every cycle.
  - Period counter free-runs regardless of holdoff, arming or tdd_sync_int.
  - First sync_out at cycle index P (first enabled cycle = 0), then every P cycles.
  - A change to tdd_sync_period takes effect at the next compare; if counter > P-1, the counter runs on to wrap at 2^SYNC_COUNT_WIDTH (documented, not guarded).
- FSM states:
  - IDLE: tdd_enable=0. Goes to READY when tdd_enable=1.
  - READY: gated = ext_raw | int_raw, masked by (~oneshot | armed).
    - emit = gated | tdd_sync_soft; on emit, go to HOLD with hold_cnt = H, or stay in READY if H = 0.
  - HOLD: ext_raw and int_raw are dropped, not queued. hold_cnt decrements each cycle; return to READY when it reaches 1.
    - Exactly H cycles are suppressed after each emit cycle.
    - tdd_sync_soft still emits in HOLD and reloads hold_cnt = H.
- Output and status:
  - sync_out <= emit: one cycle wide, latency 1 from emit. Simultaneous sources produce one pulse.
  - sync_count increments by 1 per emit, wrapping 0xFFFFFFFF -> 0.
- Arming:
  - tdd_sync_arm sets armed; any emit clears it.
  - Arm and emit in the same cycle: armed ends at 1.
  - If armed=0 and tdd_sync_arm coincides with a gated event in oneshot mode, the event is dropped and armed becomes 1.
  - tdd_sync_soft ignores arming but still clears armed.
  - With oneshot=0, the armed flag still tracks arm/emit but does not gate sources.
- Mid-operation tdd_enable fall: clears everything in the next cycle; a pending CDC edge is lost.

Test Plan:
- CDC=1, mask=01, pol=0; sync_in[0] high for 10 cycles -> exactly one sync_out pulse, 3 edges after first sample; sync_count=1.
- pol[1]=1, mask=10; falling edge on sync_in[1] -> one pulse; rising edge -> none.
- P=5, int=1, H=0 -> sync_out at cycles 5, 10, 15, 20. P=1 -> high every cycle. P=0 -> never.
- P=2, H=3 -> pulses every 4 cycles; soft strobe at an emit+2 cycle -> pulse emitted, holdoff restarts.
- oneshot=1, P=4: no arm -> no pulses; arm once -> exactly one pulse and sync_armed 1->0; arm coincident with an internal event while unarmed -> no pulse, armed=1.
- Running P=3: tdd_enable low for 1 cycle, then high -> counter restarts; next pulse 3 cycles later, sync_count=0. resetn low mid-HOLD -> all outputs 0 next cycle.
